eth_udp_tx_ctrl: RTL and testbench

Transmit sequencer in the Ethernet clock domain that turns a software "send packet" request into a UDP header handshake plus an OutFIFO streaming command. It sits between the CSR bank (request already synchronised into clk_eth) and the OUT-type packet FIFO / UDP TX stack. It drives start/length/clear of the FIFO command interface, monitors FIFO status, and reports completion or error back to CSR.

---
 rtl/eth_udp_tx_ctrl_pkg.sv | 47 ++++
 rtl/eth_udp_tx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_eth_udp_tx_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_udp_tx_ctrl_pkg.sv
// Shared types for the Ethernet UDP transmit sequencer: FIFO status/command
// structs, FSM and error-code enums, and the UDP header size.
package eth_udp_tx_ctrl_pkg;

    localparam int PTR_W = 16;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [15:0]      udp_length_t;

    localparam udp_length_t UDP_HDR_BYTES = 16'd8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        HDR     = 3'd2,
        STREAM  = 3'd3,
        RELEASE = 3'd4,
        REPORT  = 3'd5
    } fsm_udp_tx_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_NO_DATA = 2'd2,
        ERR_TIMEOUT = 2'd3
    } udp_tx_err_t;

    typedef struct packed {
        ptr_t rd_ptr;
        ptr_t wr_ptr;
        logic empty;
        logic full;
        logic done;
    } s_fifo_st_t;

    typedef struct packed {
        logic        start;
        udp_length_t length;
        logic        clear;
    } s_fifo_cmd_t;

    // Bytes buffered in the FIFO; the subtraction wraps at ptr_t width.
    function automatic ptr_t fifo_avail(input ptr_t wr_ptr, input ptr_t rd_ptr);
        return wr_ptr - rd_ptr;
    endfunction

endpackage

// File: rtl/eth_udp_tx_ctrl.sv
// Transmit sequencer: validates a send request against the OutFIFO fill level,
// hands the UDP header to the TX stack, then streams the payload with a timeout.
module eth_udp_tx_ctrl
    import eth_udp_tx_ctrl_pkg::*;
#(
    parameter int MAX_LEN     = 1472,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk_eth,
    input  logic        rst_eth,
    input  logic        send_i,
    input  logic [31:0] dst_ip_i,
    input  logic [15:0] dst_port_i,
    input  logic [15:0] src_port_i,
    input  logic [15:0] length_i,
    input  s_fifo_st_t  fifo_st_i,
    output s_fifo_cmd_t fifo_cmd_o,
    output logic        hdr_valid_o,
    input  logic        hdr_ready_i,
    output logic [31:0] hdr_ip_dst_o,
    output logic [15:0] hdr_dst_port_o,
    output logic [15:0] hdr_src_port_o,
    output logic [15:0] hdr_udp_len_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int               CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam udp_length_t      MAX_LEN_L = udp_length_t'(MAX_LEN);

    fsm_udp_tx_t      state_r;
    udp_length_t      len_r;
    logic [31:0]      ip_r;
    logic [15:0]      dport_r;
    logic [15:0]      sport_r;
    udp_length_t      udp_len_r;
    logic [CNT_W-1:0] cnt_r;
    udp_tx_err_t      pend_code_r;
    udp_tx_err_t      err_code_r;
    logic             hdr_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    s_fifo_cmd_t      cmd_r;

    ptr_t avail_s;
    logic bad_len_s;
    logic no_data_s;
    logic timeout_s;
    logic unused_st_s;

    // Request validation and stream-timeout decisions from current state and inputs
    always_comb begin
        avail_s   = fifo_avail(fifo_st_i.wr_ptr, fifo_st_i.rd_ptr);
        bad_len_s = (len_r == 16'd0) || (len_r > MAX_LEN_L);
        no_data_s = (len_r > avail_s);
        timeout_s = (cnt_r == CNT_LAST);
    end

    assign unused_st_s = fifo_st_i.empty ^ fifo_st_i.full;

    // Sequencer FSM with all outputs registered on the transitions that set them
    always_ff @(posedge clk_eth) begin
        if (rst_eth) begin
            state_r     <= IDLE;
            len_r       <= 16'd0;
            ip_r        <= 32'd0;
            dport_r     <= 16'd0;
            sport_r     <= 16'd0;
            udp_len_r   <= 16'd0;
            cnt_r       <= '0;
            pend_code_r <= ERR_OK;
            err_code_r  <= ERR_OK;
            hdr_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cmd_r       <= '0;
        end else begin
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cmd_r.clear <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (send_i) begin
                        len_r     <= length_i;
                        ip_r      <= dst_ip_i;
                        dport_r   <= dst_port_i;
                        sport_r   <= src_port_i;
                        udp_len_r <= length_i + UDP_HDR_BYTES;
                        busy_r    <= 1'b1;
                        state_r   <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_len_s) begin
                        done_r     <= 1'b1;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_BAD_LEN;
                        state_r    <= REPORT;
                    end else if (no_data_s) begin
                        done_r     <= 1'b1;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_NO_DATA;
                        state_r    <= REPORT;
                    end else begin
                        hdr_valid_r <= 1'b1;
                        state_r     <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_ready_i) begin
                        hdr_valid_r  <= 1'b0;
                        cnt_r        <= '0;
                        cmd_r.start  <= 1'b1;
                        cmd_r.length <= len_r;
                        state_r      <= STREAM;
                    end
                end
                STREAM: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (fifo_st_i.done) begin
                        cmd_r.start  <= 1'b0;
                        cmd_r.length <= 16'd0;
                        pend_code_r  <= ERR_OK;
                        state_r      <= RELEASE;
                    end else if (timeout_s) begin
                        cmd_r.start  <= 1'b0;
                        cmd_r.length <= 16'd0;
                        cmd_r.clear  <= 1'b1;
                        pend_code_r  <= ERR_TIMEOUT;
                        state_r      <= RELEASE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RELEASE: begin
                    done_r     <= 1'b1;
                    err_r      <= (pend_code_r != ERR_OK);
                    err_code_r <= pend_code_r;
                    state_r    <= REPORT;
                end
                REPORT: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    hdr_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_r       <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign fifo_cmd_o     = cmd_r;
    assign hdr_valid_o    = hdr_valid_r;
    assign hdr_ip_dst_o   = ip_r;
    assign hdr_dst_port_o = dport_r;
    assign hdr_src_port_o = sport_r;
    assign hdr_udp_len_o  = udp_len_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign err_o          = err_r;
    assign err_code_o     = err_code_r;

endmodule

// File: tb/tb_eth_udp_tx_ctrl.sv
// Self-checking bench for eth_udp_tx_ctrl: directed and randomized send requests
// compared against a transaction-level timing/outcome model.
module tb_eth_udp_tx_ctrl;
    import eth_udp_tx_ctrl_pkg::*;

    localparam int TB_MAX_LEN = 1472;
    localparam int TB_TIMEOUT = 16;

    logic        clk_eth = 1'b0;
    logic        rst_eth = 1'b1;
    logic        send_i = 1'b0;
    logic [31:0] dst_ip_i = 32'd0;
    logic [15:0] dst_port_i = 16'd0;
    logic [15:0] src_port_i = 16'd0;
    logic [15:0] length_i = 16'd0;
    s_fifo_st_t  fifo_st = '0;
    s_fifo_cmd_t fifo_cmd;
    logic        hdr_valid_o;
    logic        hdr_ready_i = 1'b0;
    logic [31:0] hdr_ip_dst_o;
    logic [15:0] hdr_dst_port_o;
    logic [15:0] hdr_src_port_o;
    logic [15:0] hdr_udp_len_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int checks = 0;
    int errors = 0;

    eth_udp_tx_ctrl #(.MAX_LEN(TB_MAX_LEN), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clk_eth(clk_eth), .rst_eth(rst_eth), .send_i(send_i),
        .dst_ip_i(dst_ip_i), .dst_port_i(dst_port_i), .src_port_i(src_port_i),
        .length_i(length_i), .fifo_st_i(fifo_st), .fifo_cmd_o(fifo_cmd),
        .hdr_valid_o(hdr_valid_o), .hdr_ready_i(hdr_ready_i),
        .hdr_ip_dst_o(hdr_ip_dst_o), .hdr_dst_port_o(hdr_dst_port_o),
        .hdr_src_port_o(hdr_src_port_o), .hdr_udp_len_o(hdr_udp_len_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk_eth = ~clk_eth;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outcome of a request: 1 bad length, 2 not enough data, 3 FIFO never finished
    // inside the allowed STREAM window (done offered in STREAM cycle done_lat), else 0.
    function automatic int model_code(input int len, input logic [15:0] wr,
                                      input logic [15:0] rd, input int done_lat);
        logic [15:0] avail;
        avail = wr - rd;
        if (len == 0 || len > TB_MAX_LEN) return 1;
        if (len > int'(avail)) return 2;
        if (done_lat < 0 || done_lat > TB_TIMEOUT - 1) return 3;
        return 0;
    endfunction

    // One request; observation k is the cycle k+1 after send is sampled (k=0 is CHECK).
    task automatic txn(input int len, input logic [15:0] wr, input logic [15:0] rd,
                       input int ready_lat, input int done_lat, input bit resend);
        int code;
        logic [31:0] ip;
        logic [15:0] dp, sp;
        int hv_cnt, hv_first, hv_bad, hs_k, st_cnt, st_first, st_last, st_bad;
        int done_k, clr_k, clr_cnt, dn_k, dn_cnt, dn_err, dn_code, post;
        bit stop;
        code = model_code(len, wr, rd, done_lat);
        ip = $urandom; dp = 16'($urandom); sp = 16'($urandom);
        hv_cnt = 0; hv_first = -1; hv_bad = 0; hs_k = -1;
        st_cnt = 0; st_first = -1; st_last = -1; st_bad = 0; done_k = -1;
        clr_k = -1; clr_cnt = 0; dn_k = -1; dn_cnt = 0; dn_err = -1; dn_code = -1;
        post = 0; stop = 1'b0;
        @(negedge clk_eth);
        send_i = 1'b1; dst_ip_i = ip; dst_port_i = dp; src_port_i = sp;
        length_i = 16'(len);
        fifo_st.wr_ptr = wr; fifo_st.rd_ptr = rd; fifo_st.empty = (wr == rd);
        fifo_st.full = 1'b0; fifo_st.done = 1'b0;
        for (int k = 0; k < 400 && !stop; k++) begin
            @(negedge clk_eth);
            send_i = 1'b0; hdr_ready_i = 1'b0; fifo_st.done = 1'b0;
            dst_ip_i = $urandom; dst_port_i = 16'($urandom);
            src_port_i = 16'($urandom); length_i = 16'($urandom);
            if (hdr_valid_o) begin
                hv_cnt++;
                if (hv_first < 0) hv_first = k;
                if (hdr_ip_dst_o !== ip || hdr_dst_port_o !== dp || hdr_src_port_o !== sp ||
                    hdr_udp_len_o !== 16'(len + 8)) hv_bad++;
                if (hv_cnt == ready_lat + 1) begin hdr_ready_i = 1'b1; hs_k = k; end
                if (resend && hv_cnt == 10) send_i = 1'b1;
            end
            if (fifo_cmd.start) begin
                st_cnt++;
                if (st_first < 0) st_first = k;
                st_last = k;
                if (fifo_cmd.length !== 16'(len)) st_bad++;
                if (done_lat >= 0 && st_cnt == done_lat + 1) begin
                    fifo_st.done = 1'b1; done_k = k;
                end
            end
            if (fifo_cmd.clear) begin clr_cnt++; clr_k = k; end
            if (done_o) begin
                dn_cnt++; dn_k = k; dn_err = int'(err_o); dn_code = int'(err_code_o);
            end
            if (dn_cnt > 0) begin
                post++;
                if (post == 4) stop = 1'b1;
            end
        end
        check("done_count", dn_cnt, 1);
        check("done_err", dn_err, (code != 0) ? 1 : 0);
        check("done_code", dn_code, code);
        check("code_hold", int'(err_code_o), code);
        check("idle_after", int'(busy_o), 0);
        check("clear_cycles", clr_cnt, (code == 3) ? 1 : 0);
        if (code == 1 || code == 2) begin
            check("err_latency", dn_k, 1);
            check("hv_never", hv_cnt, 0);
            check("start_never", st_cnt, 0);
        end else begin
            check("hv_first", hv_first, 1);
            check("hv_cycles", hv_cnt, ready_lat + 1);
            check("hdr_fields", hv_bad, 0);
            check("start_first", st_first, hs_k + 1);
            check("start_length", st_bad, 0);
            if (code == 0) begin
                check("start_cycles", st_cnt, done_lat + 1);
                check("start_last", st_last, done_k);
                check("done_latency", dn_k, done_k + 2);
            end else begin
                check("start_cycles_to", st_cnt, TB_TIMEOUT);
                check("clear_cycle", clr_k, hs_k + 1 + TB_TIMEOUT);
                check("done_after_clear", dn_k, clr_k + 1);
            end
        end
    endtask

    initial begin
        int seen_start, dn, len, avail, dl;
        logic [15:0] wr;

        repeat (3) @(negedge clk_eth);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_code", int'(err_code_o), 0);
        check("rst_hv", int'(hdr_valid_o), 0);
        check("rst_cmd", int'({fifo_cmd.start, fifo_cmd.clear}), 0);
        check("rst_cmd_len", int'(fifo_cmd.length), 0);
        check("rst_hdr_len", int'(hdr_udp_len_o), 0);
        check("rst_hdr_ip", (hdr_ip_dst_o === 32'd0) ? 1 : 0, 1);
        rst_eth = 1'b0;

        txn(64, 16'd64, 16'd0, 0, 5, 1'b0);
        txn(0, 16'd2000, 16'd0, 0, 3, 1'b0);
        txn(1500, 16'd2000, 16'd0, 0, 3, 1'b0);
        txn(100, 16'h0010, 16'hFFE8, 0, 3, 1'b0);
        txn(100, 16'h0010, 16'hFFAC, 1, 4, 1'b0);
        txn(64, 16'd64, 16'd0, 0, -1, 1'b0);
        txn(64, 16'd64, 16'd0, 50, 3, 1'b1);
        txn(TB_MAX_LEN, 16'd1472, 16'd0, 2, 0, 1'b0);
        txn(TB_MAX_LEN + 1, 16'd3000, 16'd0, 0, 0, 1'b0);
        txn(10, 16'd10, 16'd0, 0, TB_TIMEOUT - 1, 1'b0);
        txn(11, 16'd10, 16'd0, 0, 0, 1'b0);

        // Reset while streaming: payload never completes.
        @(negedge clk_eth);
        send_i = 1'b1; length_i = 16'd64; fifo_st.wr_ptr = 16'd64; fifo_st.rd_ptr = 16'd0;
        fifo_st.done = 1'b0; hdr_ready_i = 1'b1;
        seen_start = 0;
        for (int k = 0; k < 20 && seen_start == 0; k++) begin
            @(negedge clk_eth);
            send_i = 1'b0;
            if (fifo_cmd.start) seen_start = 1;
        end
        check("rst_mid_reach_stream", seen_start, 1);
        @(negedge clk_eth);
        rst_eth = 1'b1; hdr_ready_i = 1'b0;
        @(negedge clk_eth);
        check("rst_mid_start", int'(fifo_cmd.start), 0);
        check("rst_mid_busy", int'(busy_o), 0);
        check("rst_mid_hv", int'(hdr_valid_o), 0);
        dn = int'(done_o);
        rst_eth = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_eth);
            if (done_o) dn++;
        end
        check("rst_mid_no_done", dn, 0);
        txn(64, 16'd64, 16'd0, 0, 2, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(TB_MAX_LEN + 1, 2000);
                default: len = $urandom_range(1, TB_MAX_LEN);
            endcase
            if (len > 0 && $urandom_range(0, 3) == 0) avail = $urandom_range(0, len - 1);
            else avail = len + $urandom_range(0, 50);
            wr = 16'($urandom);
            dl = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TB_TIMEOUT + 3);
            txn(len, wr, wr - 16'(avail), $urandom_range(0, 6), dl, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
